cmod_io_ctrl: RTL
=================

# cmod_io_ctrl

Parametrised board I/O controller for the Cmod A7 family: conditions N raw push-buttons (synchronise, debounce, edge-detect) and drives N discrete LEDs plus one RGB LED with per-channel PWM brightness. It sits directly under the board top level, between the physical pins (BTN, LED, RGB0_*) and user logic. It generalises the fixed two-button / two-LED / one-RGB pin set to configurable counts, adds debouncing, and replaces on/off control with duty-cycle control.

## Interface

- CLK_HZ, 12000000, CLK frequency; informational, used only to derive DEBOUNCE_CYCLES defaults.
- N_BTN, 2, number of buttons (≥1).
- N_LED, 2, number of discrete LEDs (≥1).
- PWM_W, 8, PWM counter and duty width (2..16).
- DEBOUNCE_CYCLES, 120000, consecutive stable cycles required to accept a button change (10 ms @ 12 MHz; ≥2).

Ports:

- CLK  in  1  system clock; the only clock.
- RST  in  1  reset; synchronous, active-high.
- BTN  in  N_BTN  raw asynchronous button pins, 1 = pressed.
- btn_level  out  N_BTN  debounced button state.
- btn_press  out  N_BTN  1-cycle pulse on debounced 0→1.
- btn_release  out  N_BTN  1-cycle pulse on debounced 1→0.
- led_duty  in  N_LED*PWM_W  duty per LED; LED i uses bits [i*PWM_W +: PWM_W].
- rgb_duty  in  3*PWM_W  duty for red [0 +: PWM_W], green [PWM_W +: PWM_W], blue [2*PWM_W +: PWM_W].
- LED  out  N_LED  LED pins, active-high.
- RGB0_Red, RGB0_Green, RGB0_Blue  out  1 each  RGB pins, active-low (0 = lit).

## Operation

- Reset (RST=1 at an edge) clears every register: sync FFs 0, debounce counters 0, btn_level 0, btn_press/btn_release 0, PWM counter 0, latched duties 0, LED 0, RGB0_* 1. Reset mid-press or mid-period discards all state. No pulse is generated on exit from reset.
- Button path, per button independently:
  - Two-flop synchroniser s1→s2.
  - Debounce counter cnt (width ⌈log2 DEBOUNCE_CYCLES⌉). At each edge: if s2 == btn_level, cnt←0; otherwise, if cnt == DEBOUNCE_CYCLES-1, btn_level←s2 and cnt←0; else cnt←cnt+1.
  - Any mismatch run shorter than DEBOUNCE_CYCLES cycles is rejected, and the counter restarts from 0 on the next mismatch.
  - btn_press/btn_release are registered and asserted in the cycle immediately following the btn_level update, for exactly one cycle.
- PWM path:
  - One shared free-running counter pc, PWM_W bits; increments every cycle and wraps from 2^PWM_W-1 to 0.
  - Per channel, duty_q is latched from the input when pc == 2^PWM_W-1, so changes take effect only at period boundaries (glitch-free).
  - Channel on = (pc < duty_q), except duty_q == all-ones, which forces the channel on for the whole period.
  - duty 0 means fully off.
  - LED[i] = on, registered. RGB0_x = ~on, registered.

## Timing

- BTN→btn_level latency: if BTN changes and is first sampled into s1 at edge k and stays stable, btn_level updates at edge k+1+DEBOUNCE_CYCLES. btn_press/btn_release assert at edge k+2+DEBOUNCE_CYCLES.
- PWM period: 2^PWM_W cycles. On-time: duty_q cycles per period, or the full period for all-ones.
- Output pin lags pc by 1 cycle. LED[i] rises in the cycle after the edge where pc becomes 0.
- A duty written at any point in period P is latched at the end of P and applied for the whole of period P+1.
- After reset, period 0 runs with duty_q = 0 (all outputs off). Inputs present during period 0 apply from period 1.
- Simultaneous events:
  - Buttons are independent; several may update in the same cycle.
  - A duty change in the latch cycle (pc = max) is captured.

## Test plan

- Debounce accept (DEBOUNCE_CYCLES=4): BTN[0] 0→1 held 20 cycles -> btn_level[0] rises 5 edges after first sample, btn_press[0] high exactly 1 cycle one edge later, btn_release stays 0.
- Bounce reject (DEBOUNCE_CYCLES=4): BTN[1] toggles high 3 cycles, low 2, high 3, then low -> btn_level[1] stays 0, no pulses. Release after an accepted press produces one btn_release pulse.
- PWM duty (PWM_W=4): led_duty[0]=5 -> LED[0] high 5 of every 16 cycles. rgb_duty red=0 keeps RGB0_Red=1 constantly. Green=15 keeps RGB0_Green=0 constantly.
- Mid-period change: duty 4→12 written at pc=6 -> current period keeps 4 high cycles, next period shows 12.
- Reset mid-operation: assert RST during a debounce count and a PWM on-phase -> next cycle all outputs at reset values (LED=0, RGB0_*=1, btn_*=0); a held BTN is re-accepted only after the full latency.
- Multi-channel (N_BTN=4, N_LED=4): simultaneous presses on buttons 0 and 3 -> both btn_press pulses in the same cycle. Distinct duties 0/3/8/15 on LED[3:0] -> LED[0] off, LED[1] high 3, LED[2] high 8, LED[3] high 16 of 16 cycles.

Source files
------------

// File: rtl/cmod_io_ctrl_if.sv
// cmod_io_ctrl_if: user-logic side of the board I/O controller.
//   btn_level   controller -> user  debounced button state, 1 = pressed
//   btn_press   controller -> user  1-cycle pulse on debounced 0->1
//   btn_release controller -> user  1-cycle pulse on debounced 1->0
//   led_duty    user -> controller  PWM duty per LED, LED i at [i*PWM_W +: PWM_W]
//   rgb_duty    user -> controller  PWM duty red [0 +: PWM_W], green, blue
// Modports: master = user logic, slave = cmod_io_ctrl.
interface cmod_io_ctrl_if #(
  parameter int unsigned N_BTN = 2,
  parameter int unsigned N_LED = 2,
  parameter int unsigned PWM_W = 8
);
  logic [N_BTN-1:0]       btn_level;
  logic [N_BTN-1:0]       btn_press;
  logic [N_BTN-1:0]       btn_release;
  logic [N_LED*PWM_W-1:0] led_duty;
  logic [3*PWM_W-1:0]     rgb_duty;

  modport master (
    input  btn_level, btn_press, btn_release,
    output led_duty, rgb_duty
  );

  modport slave (
    output btn_level, btn_press, btn_release,
    input  led_duty, rgb_duty
  );
endinterface

// File: rtl/cmod_io_ctrl.sv
// cmod_io_ctrl: board I/O controller for the Cmod A7 family.
// Conditions N_BTN raw push-buttons (2-flop sync, debounce, edge detect) and
// drives N_LED discrete LEDs plus one RGB LED with per-channel PWM.
// Ports:
//   CLK        system clock (only clock)
//   RST        synchronous active-high reset
//   BTN        raw asynchronous button pins, 1 = pressed
//   usr        user-side interface (button status out, duties in)
//   LED        discrete LED pins, active-high
//   RGB0_Red/Green/Blue  RGB LED pins, active-low
module cmod_io_ctrl #(
  parameter int unsigned CLK_HZ          = 12000000,
  parameter int unsigned N_BTN           = 2,
  parameter int unsigned N_LED           = 2,
  parameter int unsigned PWM_W           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = CLK_HZ / 100
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_BTN-1:0]  BTN,
  cmod_io_ctrl_if.slave     usr,
  output logic [N_LED-1:0]  LED,
  output logic              RGB0_Red,
  output logic              RGB0_Green,
  output logic              RGB0_Blue
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PWM_W-1:0] PC_MAX  = '1;

  // ---------------- button path ----------------
  logic [N_BTN-1:0] s1, s2;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, rel_q;
  logic [CNT_W-1:0] cnt [N_BTN];

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1      <= '0;
      s2      <= '0;
      level_q <= '0;
      level_d <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      s1      <= BTN;
      s2      <= s1;
      // Edge pulses come from the previous-cycle level, so they land one
      // cycle after the level update and reset exit cannot fake an edge.
      level_d <= level_q;
      press_q <= level_q & ~level_d;
      rel_q   <= ~level_q & level_d;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (s2[i] == level_q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          level_q[i] <= s2[i];
          cnt[i]     <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign usr.btn_level   = level_q;
  assign usr.btn_press   = press_q;
  assign usr.btn_release = rel_q;

  // ---------------- PWM path ----------------
  logic [PWM_W-1:0] pc;
  logic [PWM_W-1:0] led_dq [N_LED];
  logic [PWM_W-1:0] rgb_dq [3];
  logic [N_LED-1:0] led_on;
  logic [2:0]       rgb_on;
  logic [N_LED-1:0] led_q;
  logic [2:0]       rgb_q;

  // All-ones duty is forced fully on; otherwise pc < duty gives duty cycles.
  always_comb begin
    led_on = '0;
    rgb_on = '0;
    for (int unsigned i = 0; i < N_LED; i++)
      led_on[i] = (led_dq[i] == PC_MAX) || (pc < led_dq[i]);
    for (int unsigned i = 0; i < 3; i++)
      rgb_on[i] = (rgb_dq[i] == PC_MAX) || (pc < rgb_dq[i]);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc    <= '0;
      led_q <= '0;
      rgb_q <= '1;
      for (int unsigned i = 0; i < N_LED; i++) led_dq[i] <= '0;
      for (int unsigned i = 0; i < 3; i++)     rgb_dq[i] <= '0;
    end else begin
      pc    <= pc + PWM_W'(1);
      led_q <= led_on;
      rgb_q <= ~rgb_on;
      // Duties are only taken at the period boundary to keep outputs glitch-free.
      if (pc == PC_MAX) begin
        for (int unsigned i = 0; i < N_LED; i++)
          led_dq[i] <= usr.led_duty[i*PWM_W +: PWM_W];
        for (int unsigned i = 0; i < 3; i++)
          rgb_dq[i] <= usr.rgb_duty[i*PWM_W +: PWM_W];
      end
    end
  end

  assign LED        = led_q;
  assign RGB0_Red   = rgb_q[0];
  assign RGB0_Green = rgb_q[1];
  assign RGB0_Blue  = rgb_q[2];

endmodule
